// File: rtl/balik_uretici.sv
// ---------------------------------------------------------------------------
// balik_uretici
//
// Stimulus-side partner of the penguin hunt checker. After a start pulse it
// drives a pseudo-random fish value every clock from an 8-bit Fibonacci LFSR.
// It counts the unpaused generation cycles and waits for the penguin block to
// report that it is done. When the penguin finishes, the block captures the
// finish time the penguin reported and compares it with its own cycle count.
// If the penguin never finishes, the block flags a timeout once MAX_SURE
// cycles have elapsed.
//
// Parameters
//   TOHUM     LFSR seed loaded on start (8'h00 is replaced by 8'h01)
//   MAX_SURE  generation cycles allowed before timeout (1..127)
//
// Ports
//   saat           in   1  system clock, rising edge
//   reset          in   1  asynchronous reset, active-low
//   basla          in   1  start pulse, honoured in BOS and SONUC
//   durdur         in   1  pause, freezes generation while high in URET
//   bitti          in   1  done flag from the penguin block
//   bitme_sure     in   7  finish time reported by the penguin block
//   avlanan_balik  out  3  fish value driven to the penguin block
//   gecerli        out  1  avlanan_balik carries a live value this cycle
//   sayac          out  7  unpaused generation cycles elapsed
//   olculen_sure   out  7  bitme_sure captured when bitti was first seen
//   uyumlu         out  1  captured bitme_sure equalled sayac at capture
//   zaman_asimi    out  1  MAX_SURE reached without bitti
// ---------------------------------------------------------------------------
module balik_uretici #(
    parameter logic [7:0] TOHUM    = 8'hA5,
    parameter int         MAX_SURE = 100
) (
    input  logic       saat,
    input  logic       reset,
    input  logic       basla,
    input  logic       durdur,
    input  logic       bitti,
    input  logic [6:0] bitme_sure,
    output logic [2:0] avlanan_balik,
    output logic       gecerli,
    output logic [6:0] sayac,
    output logic [6:0] olculen_sure,
    output logic       uyumlu,
    output logic       zaman_asimi
);

    typedef enum logic [1:0] {
        BOS   = 2'd0,
        URET  = 2'd1,
        SONUC = 2'd2
    } durum_t;

    // An all-zero LFSR would lock up, so a zero seed is replaced by 8'h01.
    localparam logic [7:0] BASLANGIC = (TOHUM == 8'h00) ? 8'h01 : TOHUM;
    localparam logic [6:0] SON_SAYAC = 7'(MAX_SURE - 1);
    localparam logic [6:0] UST_SINIR = 7'(MAX_SURE);

    durum_t     durum;
    logic [7:0] lfsr;
    logic [7:0] lfsr_sonraki;
    logic       canli;

    // Taps 8,6,5,4 give the maximal-length sequence with period 255.
    assign lfsr_sonraki = {lfsr[6:0], lfsr[7] ^ lfsr[5] ^ lfsr[4] ^ lfsr[3]};

    // The fish value is live only while generating and not paused. It is
    // taken straight from the registers so the penguin sees it in the same
    // cycle that the pause input drops.
    assign canli         = (durum == URET) && !durdur;
    assign avlanan_balik = canli ? lfsr[2:0] : 3'b000;
    assign gecerli       = canli;

    // Main controller. A paused cycle changes nothing at all, and bitti is
    // also ignored while paused. When bitti arrives on the same edge as the
    // timeout, bitti has priority. The comparison uses the count before any
    // increment, so the penguin must report the cycle on which it saw its
    // last fish.
    always_ff @(posedge saat or negedge reset) begin
        if (!reset) begin
            durum        <= BOS;
            lfsr         <= 8'h00;
            sayac        <= 7'd0;
            olculen_sure <= 7'd0;
            uyumlu       <= 1'b0;
            zaman_asimi  <= 1'b0;
        end else begin
            case (durum)
                BOS, SONUC: begin
                    if (basla) begin
                        durum        <= URET;
                        lfsr         <= BASLANGIC;
                        sayac        <= 7'd0;
                        olculen_sure <= 7'd0;
                        uyumlu       <= 1'b0;
                        zaman_asimi  <= 1'b0;
                    end
                end
                URET: begin
                    if (!durdur) begin
                        if (bitti) begin
                            olculen_sure <= bitme_sure;
                            uyumlu       <= (bitme_sure == sayac);
                            durum        <= SONUC;
                        end else if (sayac == SON_SAYAC) begin
                            lfsr        <= lfsr_sonraki;
                            sayac       <= UST_SINIR;
                            zaman_asimi <= 1'b1;
                            durum       <= SONUC;
                        end else begin
                            lfsr  <= lfsr_sonraki;
                            sayac <= sayac + 7'd1;
                        end
                    end
                end
                default: durum <= BOS;
            endcase
        end
    end

endmodule

// File: tb/tb_balik_uretici.sv
// ---------------------------------------------------------------------------
// tb_balik_uretici
//
// Directed bench for balik_uretici. It drives the block as a single linear
// sequence of steps. Expected values are worked out by hand from the LFSR
// taps (A5, 4A, 95, 2A, 54, A9, 53, A7, ...) and from the counter rules.
// ---------------------------------------------------------------------------
module tb_balik_uretici;

    logic       saat;
    logic       reset;
    logic       basla;
    logic       durdur;
    logic       bitti;
    logic [6:0] bitme_sure;
    logic [2:0] avlanan_balik;
    logic       gecerli;
    logic [6:0] sayac;
    logic [6:0] olculen_sure;
    logic       uyumlu;
    logic       zaman_asimi;

    int tests_run;
    int tests_failed;

    balik_uretici #(
        .TOHUM    (8'hA5),
        .MAX_SURE (100)
    ) dut (
        .saat          (saat),
        .reset         (reset),
        .basla         (basla),
        .durdur        (durdur),
        .bitti         (bitti),
        .bitme_sure    (bitme_sure),
        .avlanan_balik (avlanan_balik),
        .gecerli       (gecerli),
        .sayac         (sayac),
        .olculen_sure  (olculen_sure),
        .uyumlu        (uyumlu),
        .zaman_asimi   (zaman_asimi)
    );

    // Free-running 10 ns clock
    initial saat = 1'b0;
    always #5 saat = ~saat;

    // Hard time limit so the run always ends even if the sequence stalls
    initial begin
        #200000;
        $display("[TB] FAIL watchdog: observed no finish, expected finish before 200000");
        $fatal(1, "[TB] watchdog expired");
    end

    // Drive all inputs together, then let the combinational outputs settle
    task automatic applyStimulus(input logic b, input logic d, input logic bt,
                                 input logic [6:0] bs);
        basla      = b;
        durdur     = d;
        bitti      = bt;
        bitme_sure = bs;
        #1;
    endtask

    // Advance n rising edges and land 2 ns after the last one
    task automatic tick(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge saat);
        end
        #2;
    endtask

    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        tests_run++;
        assert (observed === expected)
        else begin
            tests_failed++;
            $error("[TB] FAIL %s: observed %0h expected %0h", tag, observed, expected);
        end
    endtask

    task automatic checkIdle(input string tag, input logic [6:0] exp_sayac);
        checkOutput({tag, " balik"}, 32'(avlanan_balik), 32'd0);
        checkOutput({tag, " gecerli"}, 32'(gecerli), 32'd0);
        checkOutput({tag, " sayac"}, 32'(sayac), 32'(exp_sayac));
    endtask

    // Pulse basla for one edge
    task automatic startRun();
        applyStimulus(1'b1, 1'b0, 1'b0, 7'd0);
        tick(1);
        applyStimulus(1'b0, 1'b0, 1'b0, 7'd0);
    endtask

    initial begin
        tests_run    = 0;
        tests_failed = 0;

        // Reset and idle
        reset = 1'b0;
        applyStimulus(1'b0, 1'b0, 1'b0, 7'd0);
        tick(2);
        checkIdle("in reset", 7'd0);
        reset = 1'b1;
        tick(5);
        checkIdle("idle", 7'd0);
        checkOutput("idle olculen", 32'(olculen_sure), 32'd0);
        checkOutput("idle uyumlu", 32'(uyumlu), 32'd0);
        checkOutput("idle zaman", 32'(zaman_asimi), 32'd0);

        // First three fish values after a start
        startRun();
        checkOutput("seq0 balik", 32'(avlanan_balik), 32'h5);
        checkOutput("seq0 gecerli", 32'(gecerli), 32'd1);
        checkOutput("seq0 sayac", 32'(sayac), 32'd0);
        tick(1);
        checkOutput("seq1 balik", 32'(avlanan_balik), 32'h2);
        checkOutput("seq1 sayac", 32'(sayac), 32'd1);
        tick(1);
        checkOutput("seq2 balik", 32'(avlanan_balik), 32'h5);
        checkOutput("seq2 sayac", 32'(sayac), 32'd2);

        // Match: the penguin reports 5 on the edge where sayac is 5
        tick(3);
        checkOutput("match pre sayac", 32'(sayac), 32'd5);
        applyStimulus(1'b0, 1'b0, 1'b1, 7'd5);
        tick(1);
        applyStimulus(1'b0, 1'b0, 1'b0, 7'd0);
        checkIdle("match", 7'd5);
        checkOutput("match olculen", 32'(olculen_sure), 32'd5);
        checkOutput("match uyumlu", 32'(uyumlu), 32'd1);
        checkOutput("match zaman", 32'(zaman_asimi), 32'd0);
        // bitti is ignored while holding the result
        applyStimulus(1'b0, 1'b0, 1'b1, 7'd9);
        tick(2);
        applyStimulus(1'b0, 1'b0, 1'b0, 7'd0);
        checkIdle("hold", 7'd5);
        checkOutput("hold olculen", 32'(olculen_sure), 32'd5);

        // Pause plus mismatch
        startRun();
        checkOutput("restart uyumlu", 32'(uyumlu), 32'd0);
        tick(7);
        checkOutput("prepause balik", 32'(avlanan_balik), 32'h7);
        // bitti is raised during the pause and must be ignored
        applyStimulus(1'b0, 1'b1, 1'b1, 7'd16);
        checkIdle("pause now", 7'd7);
        tick(3);
        checkIdle("pause end", 7'd7);
        applyStimulus(1'b0, 1'b0, 1'b0, 7'd0);
        checkOutput("unpause balik", 32'(avlanan_balik), 32'h7);
        checkOutput("unpause gecerli", 32'(gecerli), 32'd1);
        tick(6);
        checkOutput("mis pre sayac", 32'(sayac), 32'd13);
        applyStimulus(1'b0, 1'b0, 1'b1, 7'd16);
        tick(1);
        applyStimulus(1'b0, 1'b0, 1'b0, 7'd0);
        checkIdle("mismatch", 7'd13);
        checkOutput("mismatch olculen", 32'(olculen_sure), 32'd16);
        checkOutput("mismatch uyumlu", 32'(uyumlu), 32'd0);

        // Timeout after 100 unpaused cycles
        startRun();
        tick(99);
        checkOutput("to pre sayac", 32'(sayac), 32'd99);
        checkOutput("to pre zaman", 32'(zaman_asimi), 32'd0);
        checkOutput("to pre gecerli", 32'(gecerli), 32'd1);
        tick(1);
        checkIdle("timeout", 7'd100);
        checkOutput("timeout zaman", 32'(zaman_asimi), 32'd1);
        startRun();
        checkOutput("after to sayac", 32'(sayac), 32'd0);
        checkOutput("after to zaman", 32'(zaman_asimi), 32'd0);
        checkOutput("after to balik", 32'(avlanan_balik), 32'h5);

        // bitti on the timeout edge takes priority
        tick(99);
        applyStimulus(1'b0, 1'b0, 1'b1, 7'd99);
        tick(1);
        applyStimulus(1'b0, 1'b0, 1'b0, 7'd0);
        checkIdle("tie", 7'd99);
        checkOutput("tie zaman", 32'(zaman_asimi), 32'd0);
        checkOutput("tie uyumlu", 32'(uyumlu), 32'd1);
        checkOutput("tie olculen", 32'(olculen_sure), 32'd99);

        // Asynchronous reset in the middle of a run
        startRun();
        tick(40);
        checkOutput("mid sayac", 32'(sayac), 32'd40);
        reset = 1'b0;
        #1;
        checkIdle("async reset", 7'd0);
        #1;
        reset = 1'b1;
        tick(3);
        checkIdle("post reset", 7'd0);
        startRun();
        checkOutput("post restart balik", 32'(avlanan_balik), 32'h5);
        checkOutput("post restart gecerli", 32'(gecerli), 32'd1);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
